// File: rtl/if_fetch_unit_if.sv
// IF-stage bus bundle: ROM port, IF/ID outputs and stall/redirect controls.
//   master : fetch unit side (drives imem_addr/imem_en and the IF/ID outputs)
//   slave  : environment side (ROM, IF/ID register, hazard/branch logic)
interface if_fetch_unit_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 32
);
  logic              stall;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_en;
  logic [DATA_W-1:0] imem_data;
  logic [DATA_W-1:0] Instruction;
  logic [ADDR_W-1:0] InstructionDir;
  logic              inst_valid;
  logic [15:0]       fetch_count;

  modport master (
    input  stall, branch_taken, branch_target, imem_data,
    output imem_addr, imem_en, Instruction, InstructionDir, inst_valid, fetch_count
  );

  modport slave (
    output stall, branch_taken, branch_target, imem_data,
    input  imem_addr, imem_en, Instruction, InstructionDir, inst_valid, fetch_count
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID register.
// Keeps the PC, drives a synchronous 1-cycle-latency instruction ROM, and
// presents Instruction/InstructionDir/inst_valid every cycle. Handles decode
// stalls (PC and ROM output frozen) and branch redirects (current output
// squashed, target fetched the same cycle, one-bubble penalty).
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  if_fetch_unit_if.master: stall, branch_taken, branch_target,
//        imem_addr, imem_en, imem_data, Instruction, InstructionDir,
//        inst_valid, fetch_count
module if_fetch_unit #(
  parameter int unsigned          ADDR_W    = 7,
  parameter int unsigned          DATA_W    = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
  parameter logic [DATA_W-1:0]    NOP_INSTR = '0
) (
  input  logic           clk,
  input  logic           rst,
  if_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] f_pc_q, f_pc_d;
  logic              f_valid_q, f_valid_d;
  logic [15:0]       fetch_count_q, fetch_count_d;
  logic              out_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      f_pc_q        <= RESET_PC;
      f_valid_q     <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      f_pc_q        <= f_pc_d;
      f_valid_q     <= f_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    f_pc_d        = f_pc_q;
    f_valid_d     = f_valid_q;
    fetch_count_d = fetch_count_q;
    // A redirect squashes whatever is presented this cycle.
    out_valid     = f_valid_q & ~bus.branch_taken;

    if (bus.branch_taken) begin
      // Redirect wins over stall: the target is fetched now, so next cycle
      // presents it and the cycle after that presents target+1.
      pc_d      = bus.branch_target + ADDR_W'(1);
      f_pc_d    = bus.branch_target;
      f_valid_d = 1'b1;
      state_d   = RUN;
    end else if (bus.stall) begin
      // ROM is disabled while stalled, so its output (and ours) holds.
      if (state_q != BOOT) state_d = HOLD;
    end else begin
      pc_d      = pc_q + ADDR_W'(1);
      f_pc_d    = pc_q;
      f_valid_d = 1'b1;
      state_d   = RUN;
    end

    if (out_valid && !bus.stall) fetch_count_d = fetch_count_q + 16'd1;
  end

  assign bus.imem_addr      = bus.branch_taken ? bus.branch_target : pc_q;
  assign bus.imem_en        = bus.branch_taken | ~bus.stall;
  assign bus.Instruction    = out_valid ? bus.imem_data : NOP_INSTR;
  assign bus.InstructionDir = f_pc_q;
  assign bus.inst_valid     = out_valid;
  assign bus.fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;
  localparam int unsigned AW = 7;
  localparam int unsigned DW = 32;
  localparam logic [DW-1:0] NOP = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  if_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(7'd0), .NOP_INSTR(NOP)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Synchronous ROM with clock enable.
  logic [DW-1:0] rom [0:127];
  always @(posedge clk) if (bus.imem_en) bus.imem_data <= rom[bus.imem_addr];

  // Reference model: stream of presented addresses.
  // cur = what is presented now, nxt = next address in sequential order.
  logic          m_v;
  logic [AW-1:0] m_a, m_nxt;
  logic [15:0]   m_cnt;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;
  logic [63:0] obs, exp_v;

  // Drive inputs for the current (low) clock phase and form observed/expected.
  task automatic apply(input bit r, input bit s, input bit b, input logic [AW-1:0] t);
    logic          ev;
    logic [DW-1:0] ei;
    rst = r; bus.stall = s; bus.branch_taken = b; bus.branch_target = t;
    #1;
    ev    = m_v && !b;
    ei    = ev ? rom[m_a] : NOP;
    exp_v = {ev, m_a, ei, (b || !s), (b ? t : m_nxt), m_cnt};
    obs   = {bus.inst_valid, bus.InstructionDir, bus.Instruction, bus.imem_en,
             bus.imem_addr, bus.fetch_count};
  endtask

  // Clock edge, with the model advanced on the same inputs.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_v = 1'b0; m_a = '0; m_nxt = '0; m_cnt = '0;
    end else begin
      if (m_v && !bus.branch_taken && !bus.stall) m_cnt = m_cnt + 16'd1;
      if (bus.branch_taken) begin
        m_v = 1'b1; m_a = bus.branch_target; m_nxt = bus.branch_target + 7'd1;
      end else if (!bus.stall) begin
        m_v = 1'b1; m_a = m_nxt; m_nxt = m_nxt + 7'd1;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 128; i++) rom[i] = i * 4;
    apply(1, 0, 0, '0); tick();
    apply(1, 0, 0, '0); tick();
    apply(0, 0, 0, '0);
    n_checks++;
    if (bus.inst_valid !== 1'b0 || bus.InstructionDir !== 7'd0 ||
        bus.Instruction !== NOP || bus.fetch_count !== 16'd0) begin
      n_err++;
      $display("FAIL reset_state: v=%b dir=%0d ins=%h cnt=%0d want 0/0/0/0",
               bus.inst_valid, bus.InstructionDir, bus.Instruction, bus.fetch_count);
    end
  endtask

  // Continues from the BOOT cycle left presented by test_reset.
  task automatic test_run();
    logic [DW-1:0] want_ins [0:3];
    want_ins[0] = 32'd0; want_ins[1] = 32'd0; want_ins[2] = 32'd4; want_ins[3] = 32'd8;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) apply(0, 0, 0, '0);
      n_checks++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL run_c%0d: got %h want %h", c + 1, obs, exp_v);
      end
      n_checks++;
      if (bus.inst_valid !== (c > 0) || bus.Instruction !== want_ins[c]) begin
        n_err++; $display("FAIL run_plan_c%0d: v=%b ins=%0d want v=%b ins=%0d",
                          c + 1, bus.inst_valid, bus.Instruction, c > 0, want_ins[c]);
      end
      tick();
    end
    apply(0, 0, 0, '0);
    n_checks++;
    if (bus.fetch_count !== 16'd3) begin
      n_err++; $display("FAIL run_count: got %0d want 3", bus.fetch_count);
    end
  endtask

  // Presented Dir is 3 on entry.
  task automatic test_stall();
    tick(); apply(0, 0, 0, '0); tick();        // Dir 4 presented and accepted
    for (int c = 0; c < 5; c++) begin
      apply(0, (c < 3), 0, '0);
      n_checks++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL stall_c%0d: got %h want %h", c, obs, exp_v);
      end
      if (c < 3) begin
        n_checks++;
        if (bus.Instruction !== 32'd20 || bus.InstructionDir !== 7'd5 ||
            bus.inst_valid !== 1'b1 || bus.imem_en !== 1'b0 || bus.fetch_count !== 16'd5) begin
          n_err++; $display("FAIL stall_hold_c%0d: ins=%0d dir=%0d v=%b en=%b cnt=%0d want 20/5/1/0/5",
                            c, bus.Instruction, bus.InstructionDir, bus.inst_valid,
                            bus.imem_en, bus.fetch_count);
        end
      end
      if (c == 4) begin
        n_checks++;
        if (bus.Instruction !== 32'd24 || bus.InstructionDir !== 7'd6) begin
          n_err++; $display("FAIL stall_release: ins=%0d dir=%0d want 24/6",
                            bus.Instruction, bus.InstructionDir);
        end
      end
      tick();
    end
  endtask

  // Dir 7 presented on entry.
  task automatic test_branch();
    logic [AW-1:0] want_dir [0:2];
    want_dir[0] = 7'd7; want_dir[1] = 7'd40; want_dir[2] = 7'd41;
    for (int c = 0; c < 3; c++) begin
      apply(0, 0, (c == 0), 7'd40);
      n_checks++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL branch_c%0d: got %h want %h", c, obs, exp_v);
      end
      n_checks++;
      if (bus.inst_valid !== (c != 0) || bus.InstructionDir !== want_dir[c] ||
          (c == 1 && bus.Instruction !== 32'd160) || (c == 0 && bus.Instruction !== NOP)) begin
        n_err++; $display("FAIL branch_plan_c%0d: v=%b dir=%0d ins=%0d", c,
                          bus.inst_valid, bus.InstructionDir, bus.Instruction);
      end
      tick();
    end
  endtask

  task automatic test_branch_stall();
    for (int c = 0; c < 4; c++) begin
      apply(0, 1, (c == 0), 7'd10);
      n_checks++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL brstall_c%0d: got %h want %h", c, obs, exp_v);
      end
      n_checks++;
      if (bus.inst_valid !== (c != 0) || (c != 0 && bus.InstructionDir !== 7'd10) ||
          (c != 0 && bus.Instruction !== 32'd40)) begin
        n_err++; $display("FAIL brstall_plan_c%0d: v=%b dir=%0d ins=%0d want dir 10",
                          c, bus.inst_valid, bus.InstructionDir, bus.Instruction);
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] want_dir [0:9];
    logic          want_v   [0:9];
    bit            br;
    want_dir[0] = 7'd10;  want_dir[1] = 7'd124; want_dir[2] = 7'd125; want_dir[3] = 7'd126;
    want_dir[4] = 7'd127; want_dir[5] = 7'd0;   want_dir[6] = 7'd1;   want_dir[7] = 7'd2;
    want_dir[8] = 7'd127; want_dir[9] = 7'd0;
    for (int c = 0; c < 10; c++) want_v[c] = !(c == 0 || c == 7);
    for (int c = 0; c < 10; c++) begin
      br = (c == 0 || c == 7);
      apply(0, 0, br, (c == 0) ? 7'd124 : 7'd127);
      n_checks++;
      if (obs !== exp_v || bus.InstructionDir !== want_dir[c] || bus.inst_valid !== want_v[c]) begin
        n_err++; $display("FAIL wrap_c%0d: got %h want %h (dir want %0d)",
                          c, obs, exp_v, want_dir[c]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 2; k++) begin
      apply(0, (k == 0), 0, '0); tick();
      apply(1, (k == 0), (k == 1), 7'd50); tick();   // reset during stall / redirect
      apply(0, 0, 0, '0);
      n_checks++;
      if (bus.inst_valid !== 1'b0 || bus.InstructionDir !== 7'd0 ||
          bus.fetch_count !== 16'd0 || obs !== exp_v) begin
        n_err++; $display("FAIL reset_mid_k%0d: got %h want %h", k, obs, exp_v);
      end
      tick();
      apply(0, 0, 0, '0);
      n_checks++;
      if (bus.inst_valid !== 1'b1 || bus.InstructionDir !== 7'd0 || obs !== exp_v) begin
        n_err++; $display("FAIL reset_resume_k%0d: got %h want %h", k, obs, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_random();
    bit r, s, b;
    for (int i = 0; i < 128; i++) rom[i] = $urandom;
    apply(1, 0, 0, '0); tick();
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom_range(0, 99) < 2);
      s = ($urandom_range(0, 99) < 25);
      b = ($urandom_range(0, 99) < 15);
      apply(r, s, b, AW'($urandom));
      n_checks++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL random_c%0d: got %h want %h", c, obs, exp_v);
      end
      tick();
    end
  endtask

  initial begin
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = '0;
    m_v = 1'b0; m_a = '0; m_nxt = '0; m_cnt = '0;
    test_reset();
    test_run();
    test_stall();
    test_branch();
    test_branch_stall();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage; the producing end of the IF/ID pipeline interface.
- Keeps the program counter and drives a synchronous instruction ROM (1-cycle read latency).
- Presents Instruction and InstructionDir, plus a valid flag, to the IF/ID register every cycle.
- Handles decode-stage stalls and branch redirects, squashing wrong-path instructions.

Parameters:
- ADDR_W, 7, instruction word-address width; matches InstructionDir.
- DATA_W, 32, instruction width.
- RESET_PC, 0, first address fetched after reset.
- NOP_INSTR, 32'h0000_0000, value driven on Instruction whenever the output is not valid.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  IF/ID not accepting; hold PC and outputs.
- branch_taken  in  1  redirect request from a later stage.
- branch_target  in  ADDR_W  redirect word address.
- imem_addr  out  ADDR_W  ROM read address (combinational).
- imem_en  out  1  ROM clock enable; when low, the ROM holds its last output.
- imem_data  in  DATA_W  ROM output for the address presented the previous enabled cycle.
- Instruction  out  DATA_W  instruction to IF/ID.
- InstructionDir  out  ADDR_W  word address of Instruction.
- inst_valid  out  1  Instruction/InstructionDir carry a real instruction.
- fetch_count  out  16  number of instructions delivered as valid and accepted (stall low).

Behaviour:
- Registers:
  - pc: next address to fetch.
  - f_pc: address of the in-flight fetch.
  - f_valid: the in-flight fetch carries a real instruction.
  - state: BOOT, RUN or HOLD.
  - fetch_count.
- Reset (rst=1 at a clock edge):
  - pc=RESET_PC, f_pc=RESET_PC, f_valid=0, state=BOOT, fetch_count=0.
  - Outputs: Instruction=NOP_INSTR, InstructionDir=RESET_PC, inst_valid=0.
  - Reset overrides every other input, including in mid-stall or mid-redirect.
- Output mapping:
  - Instruction = (f_valid and not branch_taken) ? imem_data : NOP_INSTR.
  - InstructionDir = f_pc.
  - inst_valid = f_valid and not branch_taken.
- imem_addr:
  - branch_taken ? branch_target : pc.
- imem_en:
  - branch_taken or not stall.
- BOOT (first cycle after reset):
  - Issues a fetch of pc; inst_valid=0.
  - Next: pc=pc+1, f_pc=pc, f_valid=1, state=RUN.
  - stall in BOOT: stays in BOOT with nothing issued.
- RUN, no stall, no branch:
  - pc<=pc+1, f_pc<=pc, f_valid<=1.
  - Throughput of one instruction per cycle.
- stall=1, branch_taken=0 (from RUN or HOLD):
  - state=HOLD; pc, f_pc, f_valid frozen.
  - imem_en=0, so imem_data and all outputs are stable for the whole stall.
  - fetch_count does not increment.
- Leaving HOLD (stall=0):
  - Same update as RUN in that cycle; state=RUN.
- branch_taken=1 (any state except reset; priority over stall):
  - The instruction currently presented is squashed: inst_valid=0, Instruction=NOP_INSTR.
  - Fetch of branch_target is issued in the same cycle.
  - Next: f_pc=branch_target, f_valid=1, pc=branch_target+1, state=RUN.
  - Redirect penalty is exactly one bubble.
- Wrap-around:
  - pc and branch_target+1 are modulo 2^ADDR_W (127+1 -> 0); no flag is raised.
- fetch_count:
  - Increments when inst_valid=1 and stall=0.
  - Wraps at 16'hFFFF -> 0.
- Back-to-back branches:
  - Each one squashes the output of its own cycle; the last target wins.

Test Plan:
- Reset then run, ROM[i]=i*4: release rst -> cycle1 inst_valid=0; cycle2 Instruction=0, Dir=0; cycle3 Instruction=4, Dir=1; cycle4 Instruction=8, Dir=2; fetch_count=3 after cycle4.
- Stall at Dir=5 (Instruction=20) for 3 cycles -> outputs hold 20/5/valid for all 3 cycles, imem_en=0, fetch_count frozen; after release, next cycle Instruction=24, Dir=6.
- branch_taken with target 40 while Dir=7 is presented -> that cycle inst_valid=0, Instruction=0; next cycle Instruction=160, Dir=40; then Dir=41.
- branch_taken and stall together, target 10 -> branch wins: bubble, then Dir=10 valid even with stall held, which then freezes Dir=10.
- Sequential run reaching Dir=126 -> Dir sequence 126, 127, 0, 1, all valid; branch to 127 -> Dir 127 then 0.
- Assert rst mid-stall and mid-redirect -> next cycle inst_valid=0, Dir=0, fetch_count=0; fetch resumes from RESET_PC via BOOT.
